// File: rtl/dm_cmd_splitter.sv
// Splits one DataMover command into CHUNK_BYTES-sized commands with a bounded
// number in flight, and folds the per-chunk statuses into one upstream status.
module dm_cmd_splitter #(
  parameter int unsigned CHUNK_BYTES = 4096,
  parameter int unsigned MAX_OUT     = 4
) (
  input  logic        S_AXI_ACLK,
  input  logic        pi_usr_rst,
  input  logic [71:0] pi_command,
  input  logic        pi_valid,
  output logic        po_ready,
  output logic [71:0] po_dm_cmd,
  output logic        po_dm_cmd_valid,
  input  logic        pi_dm_cmd_ready,
  input  logic [7:0]  pi_dm_sts_tdata,
  input  logic        pi_dm_sts_tvalid,
  output logic        po_dm_sts_tready,
  output logic [7:0]  po_sts_tdata,
  output logic        po_sts_tvalid
);

  localparam logic [22:0] LP_CHUNK   = 23'(CHUNK_BYTES);
  localparam logic [3:0]  LP_MAX_OUT = 4'(MAX_OUT);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_REPORT
  } state_t;

  state_t      r_state, r_state_nxt;
  logic [31:0] r_cur_addr, r_cur_addr_nxt;
  logic [22:0] r_remaining, r_remaining_nxt;
  logic [3:0]  r_chunk_idx, r_chunk_idx_nxt;
  logic [3:0]  r_outstanding, r_outstanding_nxt;
  logic        r_err_slv, r_err_slv_nxt;
  logic        r_err_dec, r_err_dec_nxt;
  logic        r_err_int, r_err_int_nxt;
  logic [71:0] r_cmd, r_cmd_nxt;
  logic        r_cmd_valid, r_cmd_valid_nxt;
  logic [7:0]  r_sts_tdata, r_sts_tdata_nxt;
  logic        r_sts_tvalid, r_sts_tvalid_nxt;

  logic        r_type;
  logic [5:0]  r_dsa;
  logic        r_eof;
  logic        r_drr;
  logic [3:0]  r_tag;

  logic        w_req_take;
  logic        w_cmd_take;
  logic        w_sts_take;
  logic [3:0]  w_out_nxt;
  logic        w_room;
  logic        w_sts_int;
  logic        w_slv_nxt;
  logic        w_dec_nxt;
  logic        w_int_nxt;
  logic        w_err_nxt;
  logic        w_cur_last;
  logic [22:0] w_cur_btt;
  logic [31:0] w_adv_addr;
  logic [22:0] w_adv_rem;
  logic [3:0]  w_adv_idx;
  logic        w_unused;

  function automatic logic [71:0] f_chunk(
    input logic [31:0] addr,
    input logic [22:0] rem,
    input logic [3:0]  idx,
    input logic        typ,
    input logic [5:0]  dsa,
    input logic        eof,
    input logic        drr
  );
    logic        last;
    logic [22:0] btt;
    last = (rem <= LP_CHUNK);
    btt  = last ? rem : LP_CHUNK;
    return {4'h0, idx, addr, drr, eof & last, dsa, typ, btt};
  endfunction

  assign w_unused   = ^{pi_command[71:68], pi_dm_sts_tdata[3:0]};

  assign w_req_take = pi_valid && (r_state == ST_IDLE);
  assign w_cmd_take = r_cmd_valid && pi_dm_cmd_ready;
  // Statuses in IDLE or with nothing outstanding are dropped entirely.
  assign w_sts_take = pi_dm_sts_tvalid && (r_state != ST_IDLE) && (r_outstanding != '0);
  assign w_out_nxt  = r_outstanding + {3'b000, w_cmd_take} - {3'b000, w_sts_take};
  assign w_room     = (w_out_nxt < LP_MAX_OUT);

  assign w_sts_int  = pi_dm_sts_tdata[4] | (~pi_dm_sts_tdata[7] & ~|pi_dm_sts_tdata[6:4]);
  assign w_slv_nxt  = r_err_slv | (w_sts_take & pi_dm_sts_tdata[6]);
  assign w_dec_nxt  = r_err_dec | (w_sts_take & pi_dm_sts_tdata[5]);
  assign w_int_nxt  = r_err_int | (w_sts_take & w_sts_int);
  assign w_err_nxt  = w_slv_nxt | w_dec_nxt | w_int_nxt;

  assign w_cur_last = (r_remaining <= LP_CHUNK);
  assign w_cur_btt  = w_cur_last ? r_remaining : LP_CHUNK;
  assign w_adv_addr = r_cur_addr + {9'd0, w_cur_btt};
  assign w_adv_rem  = r_remaining - w_cur_btt;
  assign w_adv_idx  = r_chunk_idx + 4'd1;

  always_ff @(posedge S_AXI_ACLK) begin
    if (pi_usr_rst) begin
      r_state       <= ST_IDLE;
      r_cur_addr    <= '0;
      r_remaining   <= '0;
      r_chunk_idx   <= '0;
      r_outstanding <= '0;
      r_err_slv     <= 1'b0;
      r_err_dec     <= 1'b0;
      r_err_int     <= 1'b0;
      r_cmd         <= '0;
      r_cmd_valid   <= 1'b0;
      r_sts_tdata   <= '0;
      r_sts_tvalid  <= 1'b0;
    end else begin
      r_state       <= r_state_nxt;
      r_cur_addr    <= r_cur_addr_nxt;
      r_remaining   <= r_remaining_nxt;
      r_chunk_idx   <= r_chunk_idx_nxt;
      r_outstanding <= r_outstanding_nxt;
      r_err_slv     <= r_err_slv_nxt;
      r_err_dec     <= r_err_dec_nxt;
      r_err_int     <= r_err_int_nxt;
      r_cmd         <= r_cmd_nxt;
      r_cmd_valid   <= r_cmd_valid_nxt;
      r_sts_tdata   <= r_sts_tdata_nxt;
      r_sts_tvalid  <= r_sts_tvalid_nxt;
    end
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (pi_usr_rst) begin
      r_type <= 1'b0;
      r_dsa  <= '0;
      r_eof  <= 1'b0;
      r_drr  <= 1'b0;
      r_tag  <= '0;
    end else if (w_req_take) begin
      r_type <= pi_command[23];
      r_dsa  <= pi_command[29:24];
      r_eof  <= pi_command[30];
      r_drr  <= pi_command[31];
      r_tag  <= pi_command[67:64];
    end
  end

  always_comb begin
    r_state_nxt       = r_state;
    r_cur_addr_nxt    = r_cur_addr;
    r_remaining_nxt   = r_remaining;
    r_chunk_idx_nxt   = r_chunk_idx;
    r_outstanding_nxt = w_out_nxt;
    r_err_slv_nxt     = w_slv_nxt;
    r_err_dec_nxt     = w_dec_nxt;
    r_err_int_nxt     = w_int_nxt;
    r_cmd_nxt         = r_cmd;
    r_cmd_valid_nxt   = r_cmd_valid;
    r_sts_tdata_nxt   = r_sts_tdata;
    r_sts_tvalid_nxt  = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (pi_valid) begin
          r_cur_addr_nxt    = pi_command[63:32];
          r_remaining_nxt   = pi_command[22:0];
          r_chunk_idx_nxt   = '0;
          r_outstanding_nxt = '0;
          r_err_slv_nxt     = 1'b0;
          r_err_dec_nxt     = 1'b0;
          r_err_int_nxt     = 1'b0;
          if (pi_command[22:0] == '0) begin
            r_err_int_nxt    = 1'b1;
            r_sts_tdata_nxt  = {4'b0001, pi_command[67:64]};
            r_sts_tvalid_nxt = 1'b1;
            r_state_nxt      = ST_REPORT;
          end else begin
            // First chunk is built straight from the request so it is valid next cycle.
            r_cmd_nxt       = f_chunk(pi_command[63:32], pi_command[22:0], 4'd0,
                                      pi_command[23], pi_command[29:24],
                                      pi_command[30], pi_command[31]);
            r_cmd_valid_nxt = 1'b1;
            r_state_nxt     = ST_ISSUE;
          end
        end
      end

      ST_ISSUE: begin
        if (w_cmd_take && w_cur_last) begin
          r_cur_addr_nxt  = w_adv_addr;
          r_remaining_nxt = w_adv_rem;
          r_chunk_idx_nxt = w_adv_idx;
          r_cmd_valid_nxt = 1'b0;
          r_state_nxt     = ST_DRAIN;
        end else if (w_err_nxt) begin
          // A command already on the bus must complete its handshake before draining.
          if (w_cmd_take || !r_cmd_valid) begin
            if (w_cmd_take) begin
              r_cur_addr_nxt  = w_adv_addr;
              r_remaining_nxt = w_adv_rem;
              r_chunk_idx_nxt = w_adv_idx;
            end
            r_cmd_valid_nxt = 1'b0;
            r_state_nxt     = ST_DRAIN;
          end
        end else if (w_cmd_take) begin
          r_cur_addr_nxt  = w_adv_addr;
          r_remaining_nxt = w_adv_rem;
          r_chunk_idx_nxt = w_adv_idx;
          r_cmd_valid_nxt = w_room;
          if (w_room) begin
            r_cmd_nxt = f_chunk(w_adv_addr, w_adv_rem, w_adv_idx, r_type, r_dsa, r_eof, r_drr);
          end
        end else if (!r_cmd_valid && w_room) begin
          r_cmd_nxt       = f_chunk(r_cur_addr, r_remaining, r_chunk_idx, r_type, r_dsa, r_eof, r_drr);
          r_cmd_valid_nxt = 1'b1;
        end
      end

      ST_DRAIN: begin
        if (r_outstanding == '0) begin
          r_sts_tdata_nxt  = {~(r_err_slv | r_err_dec | r_err_int), r_err_slv, r_err_dec, r_err_int, r_tag};
          r_sts_tvalid_nxt = 1'b1;
          r_state_nxt      = ST_REPORT;
        end
      end

      ST_REPORT: begin
        r_state_nxt = ST_IDLE;
      end

      default: begin
        r_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign po_ready         = (r_state == ST_IDLE) && !pi_usr_rst;
  assign po_dm_cmd        = r_cmd;
  assign po_dm_cmd_valid  = r_cmd_valid;
  assign po_dm_sts_tready = 1'b1;
  assign po_sts_tdata     = r_sts_tdata;
  assign po_sts_tvalid    = r_sts_tvalid;

endmodule

// File: tb/tb_dm_cmd_splitter.sv
// Directed bench for dm_cmd_splitter; expected chunk commands and statuses are
// queued as each request is driven and checked as the DUT emits them.
module tb_dm_cmd_splitter;

  logic        clk = 1'b0;
  logic        rst;
  logic [71:0] pi_command;
  logic        pi_valid;
  logic        po_ready;
  logic [71:0] po_dm_cmd;
  logic        po_dm_cmd_valid;
  logic        dm_ready;
  logic [7:0]  sts_tdata;
  logic        sts_tvalid;
  logic        po_dm_sts_tready;
  logic [7:0]  po_sts_tdata;
  logic        po_sts_tvalid;

  int n_cmp = 0;
  int n_err = 0;
  int n_acc = 0;
  int n_sts = 0;

  logic [71:0] exp_cmd[$];
  logic [7:0]  exp_sts[$];

  always #5 clk = ~clk;

  dm_cmd_splitter #(.CHUNK_BYTES(4096), .MAX_OUT(2)) dut (
    .S_AXI_ACLK       (clk),
    .pi_usr_rst       (rst),
    .pi_command       (pi_command),
    .pi_valid         (pi_valid),
    .po_ready         (po_ready),
    .po_dm_cmd        (po_dm_cmd),
    .po_dm_cmd_valid  (po_dm_cmd_valid),
    .pi_dm_cmd_ready  (dm_ready),
    .pi_dm_sts_tdata  (sts_tdata),
    .pi_dm_sts_tvalid (sts_tvalid),
    .po_dm_sts_tready (po_dm_sts_tready),
    .po_sts_tdata     (po_sts_tdata),
    .po_sts_tvalid    (po_sts_tvalid)
  );

  function automatic logic [71:0] mk(input logic [31:0] a, input logic [22:0] btt,
                                     input logic typ, input logic [5:0] dsa,
                                     input logic eof, input logic drr, input logic [3:0] tag);
    return {4'h0, tag, a, drr, eof, dsa, typ, btt};
  endfunction

  task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic req(input logic [71:0] c);
    pi_command = c;
    pi_valid   = 1'b1;
    for (int t = 0; t < 20 && !po_ready; t++) tick(1);
    chk("req_ready", 72'(po_ready), 72'(1));
    tick(1);
    pi_valid   = 1'b0;
    pi_command = '0;
  endtask

  task automatic send_sts(input logic [7:0] d);
    sts_tdata  = d;
    sts_tvalid = 1'b1;
    tick(1);
    sts_tvalid = 1'b0;
    sts_tdata  = '0;
  endtask

  task automatic wait_sts(input int target);
    for (int t = 0; t < 60 && n_sts < target; t++) tick(1);
    chk("sts_arrived", 72'(n_sts), 72'(target));
    chk("sts_one_cycle", 72'(po_sts_tvalid), 72'(0));
    chk("ready_after_report", 72'(po_ready), 72'(1));
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (po_dm_cmd_valid && dm_ready) begin
        n_acc++;
        chk("cmd_expected", 72'(exp_cmd.size() != 0), 72'(1));
        if (exp_cmd.size() != 0) chk("cmd", po_dm_cmd, exp_cmd.pop_front());
      end
      if (po_sts_tvalid) begin
        n_sts++;
        chk("sts_expected", 72'(exp_sts.size() != 0), 72'(1));
        if (exp_sts.size() != 0) chk("sts", 72'(po_sts_tdata), 72'(exp_sts.pop_front()));
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int sbase;
    logic [71:0] c0;

    rst        = 1'b1;
    pi_valid   = 1'b0;
    pi_command = '0;
    dm_ready   = 1'b0;
    sts_tdata  = '0;
    sts_tvalid = 1'b0;
    tick(3);
    chk("rst_ready", 72'(po_ready), 72'(0));
    chk("rst_cmd", po_dm_cmd, 72'(0));
    chk("rst_cmd_valid", 72'(po_dm_cmd_valid), 72'(0));
    chk("rst_sts_tdata", 72'(po_sts_tdata), 72'(0));
    chk("rst_sts_tvalid", 72'(po_sts_tvalid), 72'(0));
    chk("rst_sts_tready", 72'(po_dm_sts_tready), 72'(1));
    rst = 1'b0;
    tick(1);
    chk("idle_ready", 72'(po_ready), 72'(1));

    // Single chunk
    dm_ready = 1'b1;
    exp_cmd.push_back(mk(32'h1000_0000, 23'd100, 1'b0, 6'h00, 1'b1, 1'b0, 4'h0));
    exp_sts.push_back(8'h85);
    req(mk(32'h1000_0000, 23'd100, 1'b0, 6'h00, 1'b1, 1'b0, 4'h5));
    chk("first_valid", 72'(po_dm_cmd_valid), 72'(1));
    chk("busy_ready", 72'(po_ready), 72'(0));
    tick(3);
    chk("single_count", 72'(n_acc), 72'(1));
    send_sts(8'h80);
    wait_sts(1);

    // Three-way split, also copies type/DSA/DRR
    base = n_acc;
    exp_cmd.push_back(mk(32'h2000_0000, 23'd4096, 1'b1, 6'h2A, 1'b0, 1'b1, 4'h0));
    exp_cmd.push_back(mk(32'h2000_1000, 23'd4096, 1'b1, 6'h2A, 1'b0, 1'b1, 4'h1));
    exp_cmd.push_back(mk(32'h2000_2000, 23'd1808, 1'b1, 6'h2A, 1'b1, 1'b1, 4'h2));
    exp_sts.push_back(8'h8A);
    req(mk(32'h2000_0000, 23'd10000, 1'b1, 6'h2A, 1'b1, 1'b1, 4'hA));
    tick(3);
    chk("split_limit_count", 72'(n_acc - base), 72'(2));
    chk("split_limit_valid", 72'(po_dm_cmd_valid), 72'(0));
    send_sts(8'h80);
    tick(2);
    chk("split_count", 72'(n_acc - base), 72'(3));
    send_sts(8'h80);
    send_sts(8'h80);
    wait_sts(2);

    // Outstanding limit: each status releases exactly one command
    base = n_acc;
    for (int i = 0; i < 5; i++)
      exp_cmd.push_back(mk(32'h5000_0000 + 32'(i) * 32'h1000, 23'd4096, 1'b0, 6'h00,
                           (i == 4), 1'b0, 4'(i)));
    exp_sts.push_back(8'h83);
    req(mk(32'h5000_0000, 23'd20480, 1'b0, 6'h00, 1'b1, 1'b0, 4'h3));
    tick(4);
    for (int i = 0; i < 3; i++) begin
      chk("limit_held", 72'(n_acc - base), 72'(2 + i));
      chk("limit_valid_low", 72'(po_dm_cmd_valid), 72'(0));
      send_sts(8'h80);
      chk("limit_release", 72'(po_dm_cmd_valid), 72'(1));
      tick(1);
    end
    chk("limit_total", 72'(n_acc - base), 72'(5));
    send_sts(8'h80);
    send_sts(8'h80);
    wait_sts(3);

    // Back-pressure
    base = n_acc;
    dm_ready = 1'b0;
    c0 = mk(32'h3000_0000, 23'd4096, 1'b0, 6'h00, 1'b0, 1'b0, 4'h0);
    exp_cmd.push_back(c0);
    exp_cmd.push_back(mk(32'h3000_1000, 23'd4096, 1'b0, 6'h00, 1'b1, 1'b0, 4'h1));
    exp_sts.push_back(8'h87);
    req(mk(32'h3000_0000, 23'd8192, 1'b0, 6'h00, 1'b1, 1'b0, 4'h7));
    for (int i = 0; i < 5; i++) begin
      chk("bp_cmd_stable", po_dm_cmd, c0);
      chk("bp_valid_held", 72'(po_dm_cmd_valid), 72'(1));
      tick(1);
    end
    dm_ready = 1'b1;
    tick(3);
    chk("bp_count", 72'(n_acc - base), 72'(2));
    send_sts(8'h80);
    send_sts(8'h80);
    wait_sts(4);

    // Error abort on SLVERR
    base = n_acc;
    exp_cmd.push_back(mk(32'h4000_0000, 23'd4096, 1'b0, 6'h00, 1'b0, 1'b0, 4'h0));
    exp_cmd.push_back(mk(32'h4000_1000, 23'd4096, 1'b0, 6'h00, 1'b0, 1'b0, 4'h1));
    exp_sts.push_back(8'h49);
    req(mk(32'h4000_0000, 23'd16384, 1'b0, 6'h00, 1'b1, 1'b0, 4'h9));
    tick(3);
    send_sts(8'h40);
    tick(3);
    chk("abort_count", 72'(n_acc - base), 72'(2));
    chk("abort_valid_low", 72'(po_dm_cmd_valid), 72'(0));
    chk("abort_draining", 72'(po_sts_tvalid), 72'(0));
    send_sts(8'h80);
    wait_sts(5);

    // OKAY clear with no error bit reports INTERR
    exp_cmd.push_back(mk(32'h0000_0040, 23'd16, 1'b0, 6'h00, 1'b0, 1'b0, 4'h0));
    exp_sts.push_back(8'h14);
    req(mk(32'h0000_0040, 23'd16, 1'b0, 6'h00, 1'b0, 1'b0, 4'h4));
    tick(2);
    send_sts(8'h00);
    wait_sts(6);

    // BTT == 0
    base = n_acc;
    exp_sts.push_back(8'h1C);
    req(mk(32'h6000_0000, 23'd0, 1'b0, 6'h00, 1'b1, 1'b0, 4'hC));
    chk("btt0_pulse", 72'(po_sts_tvalid), 72'(1));
    chk("btt0_no_cmd", 72'(po_dm_cmd_valid), 72'(0));
    wait_sts(7);
    chk("btt0_count", 72'(n_acc - base), 72'(0));

    // Reset in the middle of ISSUE, then late statuses
    base  = n_acc;
    sbase = n_sts;
    exp_cmd.push_back(mk(32'h7000_0000, 23'd4096, 1'b0, 6'h00, 1'b0, 1'b0, 4'h0));
    exp_cmd.push_back(mk(32'h7000_1000, 23'd4096, 1'b0, 6'h00, 1'b0, 1'b0, 4'h1));
    req(mk(32'h7000_0000, 23'd16384, 1'b0, 6'h00, 1'b1, 1'b0, 4'h1));
    tick(3);
    chk("mid_count", 72'(n_acc - base), 72'(2));
    rst = 1'b1;
    tick(1);
    chk("mid_rst_cmd", po_dm_cmd, 72'(0));
    chk("mid_rst_valid", 72'(po_dm_cmd_valid), 72'(0));
    chk("mid_rst_ready", 72'(po_ready), 72'(0));
    chk("mid_rst_sts", 72'(po_sts_tdata), 72'(0));
    tick(1);
    rst = 1'b0;
    send_sts(8'h80);
    send_sts(8'h40);
    tick(5);
    chk("mid_no_report", 72'(n_sts - sbase), 72'(0));
    chk("mid_idle_ready", 72'(po_ready), 72'(1));
    chk("mid_idle_valid", 72'(po_dm_cmd_valid), 72'(0));

    // Address wrap at 2^32
    exp_cmd.push_back(mk(32'hFFFF_F800, 23'd4096, 1'b0, 6'h00, 1'b0, 1'b0, 4'h0));
    exp_cmd.push_back(mk(32'h0000_0800, 23'd4096, 1'b0, 6'h00, 1'b1, 1'b0, 4'h1));
    exp_sts.push_back(8'h82);
    req(mk(32'hFFFF_F800, 23'd8192, 1'b0, 6'h00, 1'b1, 1'b0, 4'h2));
    tick(3);
    send_sts(8'h80);
    send_sts(8'h80);
    wait_sts(8);

    chk("cmd_queue_empty", 72'(exp_cmd.size()), 72'(0));
    chk("sts_queue_empty", 72'(exp_sts.size()), 72'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dm_cmd_splitter.md
# dm_cmd_splitter

Command splitter between the AXI-Lite DataMover command register block and the AXI DataMover command/status ports. It accepts one 72-bit DataMover command and breaks its byte count into chunks of at most CHUNK_BYTES. Each chunk is issued as a separate DataMover command, with up to MAX_OUT chunks in flight. It collects the per-chunk statuses and returns one aggregated 8-bit status upstream in the same format the DataMover uses.

## Interface
- CHUNK_BYTES, 4096: maximum BTT per issued command; power of two, 16..2^22.
- MAX_OUT, 4: maximum outstanding issued-but-unacknowledged commands; 1..15.
- S_AXI_ACLK  in  1  single clock, rising edge.
- pi_usr_rst  in  1  reset is synchronous and active-high.
- pi_command  in  72  request: [22:0] BTT, [23] type, [29:24] DSA, [30] EOF, [31] DRR, [63:32] SADDR, [67:64] TAG, [71:68] reserved.
- pi_valid  in  1  request valid; held until po_ready.
- po_ready  out  1  request accepted when pi_valid && po_ready.
- po_dm_cmd  out  72  chunk command to the DataMover.
- po_dm_cmd_valid  out  1  chunk command valid.
- pi_dm_cmd_ready  in  1  DataMover accepts command.
- pi_dm_sts_tdata  in  8  DataMover status: [3:0] tag, [4] INTERR, [5] DECERR, [6] SLVERR, [7] OKAY.
- pi_dm_sts_tvalid  in  1  status valid.
- po_dm_sts_tready  out  1  constant 1; status is never back-pressured.
- po_sts_tdata  out  8  aggregated status, same bit layout as the DataMover status.
- po_sts_tvalid  out  1  one-cycle pulse carrying the aggregated status.

## Operation
- States: IDLE, ISSUE, DRAIN, REPORT.
- IDLE:
  - po_ready=1.
  - On a handshake: latch SADDR into cur_addr, BTT into remaining, and latch type/DSA/EOF/DRR/TAG; clear the error flags, outstanding and chunk_idx.
  - BTT==0 goes directly to REPORT with INTERR set and nothing issued.
  - Otherwise go to ISSUE.
- Chunk command fields:
  - BTT = min(remaining, CHUNK_BYTES).
  - SADDR = cur_addr.
  - type, DSA and DRR are copied from the request.
  - EOF = request EOF only on the final chunk (remaining <= CHUNK_BYTES), else 0.
  - TAG = chunk_idx[3:0].
  - [71:68] = 0.
- ISSUE:
  - po_dm_cmd_valid=1 while outstanding < MAX_OUT.
  - On a command handshake: cur_addr += chunk BTT (32-bit modulo, wraps at 2^32), remaining -= chunk BTT, chunk_idx++, outstanding++.
  - When the final chunk is accepted, go to DRAIN.
- Status handling, in any non-IDLE state:
  - Every pi_dm_sts_tvalid decrements outstanding.
  - SLVERR, DECERR and INTERR are OR-ed into sticky flags; OKAY=0 with no error bit set sets INTERR.
  - Status tags are not checked.
- Error abort: any sticky error in ISSUE stops further issue. If no command is being presented, go to DRAIN. If po_dm_cmd_valid is high, finish that handshake first, then go to DRAIN.
- DRAIN: wait until outstanding==0, then go to REPORT.
- REPORT:
  - po_sts_tvalid=1 for one cycle.
  - po_sts_tdata = {~|err, SLVERR, DECERR, INTERR, request TAG}.
  - Then return to IDLE.
- Simultaneous command accept and status receipt in the same cycle: outstanding is unchanged.
- A status that arrives in IDLE, or that would underflow outstanding, is dropped; outstanding saturates at 0.
- Reset mid-operation:
  - All state clears to IDLE and in-flight commands are abandoned.
  - Statuses arriving after reset are dropped per the IDLE rule.
  - No po_sts_tvalid is produced for the aborted request.

## Timing
- Reset values: po_ready=0 while reset is asserted, and 1 in IDLE from the first cycle after reset. po_dm_cmd=0, po_dm_cmd_valid=0, po_sts_tdata=0, po_sts_tvalid=0, po_dm_sts_tready=1.
- po_dm_cmd and po_dm_cmd_valid are registered.
  - The first chunk is valid one cycle after the request handshake.
  - When pi_dm_cmd_ready is held high, one chunk issues per cycle until the MAX_OUT limit.
  - po_dm_cmd stays stable while valid && !ready; valid never drops without a handshake.
- Once the outstanding limit is reached, a status decrement re-enables valid on the following cycle.
- po_sts_tvalid rises one cycle after outstanding reaches 0 in DRAIN. With BTT==0 it rises one cycle after the request handshake.
- po_ready is low from the handshake cycle +1 until the cycle after REPORT.

## Test plan
- Single chunk: BTT=100, SADDR=0x1000_0000, EOF=1, TAG=5, dm ready=1, OKAY status 0x80 3 cycles later -> exactly one command: BTT=100, SADDR=0x1000_0000, EOF=1, TAG=0. Then po_sts_tdata=0x85 for one cycle.
- Split: BTT=10000, CHUNK_BYTES=4096, SADDR=0x2000_0000 -> three chunks of 4096/4096/1808 at 0x2000_0000/0x2000_1000/0x2000_2000, tags 0/1/2, EOF only on the third. After three 0x80 statuses, po_sts_tdata=0x80|TAG.
- Outstanding limit: MAX_OUT=2, BTT=5×4096, no status returned -> exactly 2 commands accepted, then valid stays low. Each status releases one more command.
- Back-pressure: pi_dm_cmd_ready low for 5 cycles -> po_dm_cmd stays stable and valid stays high; the address advances only on handshake.
- Error abort: BTT=4×4096, first status 0x40 (SLVERR) -> no new command after abort, drain of those in flight, then po_sts_tdata=0x40|TAG.
- Edge cases:
  - BTT=0 -> no command issued; po_sts_tdata=0x10|TAG.
  - Reset asserted mid-ISSUE, then statuses arrive -> outputs return to reset values, statuses are ignored, and no po_sts_tvalid appears.
